// File: rtl/gray_step_if.sv
// Handshake bundle for gray_step_decoder: Gray input and clear from the source,
// decoded position/step/error status back to the consumer.
interface gray_step_if #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
);
    logic [3:0]       g;
    logic             clr;
    logic [3:0]       bin;
    logic [CNT_W-1:0] pos;
    logic             step;
    logic             dir;
    logic             err;
    logic [ERR_W-1:0] err_cnt;
    logic             locked;

    modport master (
        output g, clr,
        input  bin, pos, step, dir, err, err_cnt, locked
    );

    modport slave (
        input  g, clr,
        output bin, pos, step, dir, err, err_cnt, locked
    );
endinterface

// File: rtl/gray_step_decoder.sv
// 4-bit Gray decoder/tracker: single-step up/down detection, wrapping position, saturating
// error count. Define GRAY_SYNC_EN to insert a synchronizer flop ahead of g_q for async sources.
module gray_step_decoder #(
    parameter int CNT_W = 8,
    parameter int ERR_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    gray_step_if.slave  bus
);

    typedef enum logic [1:0] {INIT, TRACK, FAULT} state_t;

    function automatic logic [3:0] gray2bin(input logic [3:0] gw);
        logic [3:0] b;
        b[3] = gw[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ gw[i];
        return b;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
        return (&c) ? c : c + ERR_W'(1);
    endfunction

    logic [3:0]       g_q;
    logic [3:0]       g_p;
    logic [3:0]       diff;
    logic [3:0]       bin_new;
    logic [3:0]       bin_old;
    logic             one_bit;
    logic             step_up;

    state_t           state;
    logic [3:0]       bin_q;
    logic [CNT_W-1:0] pos_q;
    logic             step_q;
    logic             dir_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic             locked_q;

    // Input capture stage
`ifdef GRAY_SYNC_EN
    logic [3:0] g_meta;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_meta <= 4'd0;
            g_q    <= 4'd0;
        end else begin
            g_meta <= bus.g;
            g_q    <= g_meta;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) g_q <= 4'd0;
        else        g_q <= bus.g;
    end
`endif

    assign diff    = g_q ^ g_p;
    assign one_bit = (diff != 4'd0) && ((diff & (diff - 4'd1)) == 4'd0);
    assign bin_new = gray2bin(g_q);
    assign bin_old = gray2bin(g_p);
    assign step_up = (bin_new == bin_old + 4'd1);

    // Classification / tracking stage; g_p follows g_q every cycle so each
    // sample is always compared against its immediate predecessor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            g_p       <= 4'd0;
            bin_q     <= 4'd0;
            pos_q     <= '0;
            step_q    <= 1'b0;
            dir_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            g_p    <= g_q;
            bin_q  <= bin_new;
            step_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.clr) begin
                state     <= INIT;
                pos_q     <= '0;
                err_cnt_q <= '0;
                locked_q  <= 1'b0;
            end else begin
                case (state)
                    INIT: begin
                        state    <= TRACK;
                        locked_q <= 1'b1;
                    end
                    TRACK: begin
                        if (one_bit) begin
                            step_q <= 1'b1;
                            dir_q  <= step_up;
                            pos_q  <= step_up ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
                        end else if (diff != 4'd0) begin
                            err_q     <= 1'b1;
                            err_cnt_q <= sat_inc(err_cnt_q);
                            state     <= FAULT;
                            locked_q  <= 1'b0;
                        end
                    end
                    FAULT: ;
                    default: begin
                        state    <= INIT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.bin     = bin_q;
    assign bus.pos     = pos_q;
    assign bus.step    = step_q;
    assign bus.dir     = dir_q;
    assign bus.err     = err_q;
    assign bus.err_cnt = err_cnt_q;
    assign bus.locked  = locked_q;

endmodule
